// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Brief    : Shared refill FSM encoding, default geometry and width helpers
//            for the instruction-cache way data array.
// Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

   localparam int c_NUM_WAYS          = 2;
   localparam int c_ICACHE_DATA_WIDTH = 256;
   localparam int c_ICACHE_INDEX_WIDTH = 6;
   localparam int c_BEAT_WIDTH        = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fill_state_e;

   // Field widths never drop to zero, so single-way / single-beat builds still elaborate.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/icache_data_bank.sv
`default_nettype none
// ============================================================================
// Module   : icache_data_bank
// Brief    : One cache way: line storage with per-beat writes and a
//            registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module icache_data_bank
   import icache_pkg::*;
#(
   parameter  int DATA_W  = c_ICACHE_DATA_WIDTH,
   parameter  int INDEX_W = c_ICACHE_INDEX_WIDTH,
   parameter  int BEAT_W  = c_BEAT_WIDTH,
   localparam int BEATS   = DATA_W / BEAT_W,
   localparam int CNT_W   = clog2_min1(BEATS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_rd_en,
   input  logic [INDEX_W-1:0] i_rd_index,
   output logic [DATA_W-1:0]  o_rd_data,
   input  logic               i_wr_en,
   input  logic [INDEX_W-1:0] i_wr_index,
   input  logic [CNT_W-1:0]   i_wr_beat,
   input  logic [BEAT_W-1:0]  i_wr_data
);

   // Line storage deliberately has no reset; line validity lives in the tag array.
   logic [DATA_W-1:0] r_mem [2**INDEX_W];
   logic [DATA_W-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      for (int b = 0; b < BEATS; b++) begin
         if (i_wr_en && (i_wr_beat == CNT_W'(b))) begin
            r_mem[i_wr_index][b*BEAT_W +: BEAT_W] <= i_wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_index];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/icache_way_data_array.sv
`default_nettype none
// ============================================================================
// Module   : icache_way_data_array
// Brief    : Multi-way I-cache data array: set-wide reads, beat-wise refill
//            controlled by an IDLE/FILL/DONE sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module icache_way_data_array
   import icache_pkg::*;
#(
   parameter  int NUM_WAYS           = c_NUM_WAYS,
   parameter  int ICACHE_DATA_WIDTH  = c_ICACHE_DATA_WIDTH,
   parameter  int ICACHE_INDEX_WIDTH = c_ICACHE_INDEX_WIDTH,
   parameter  int BEAT_WIDTH         = c_BEAT_WIDTH,
   localparam int WAY_W              = clog2_min1(NUM_WAYS),
   localparam int BEATS              = ICACHE_DATA_WIDTH / BEAT_WIDTH,
   localparam int CNT_W              = clog2_min1(BEATS)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  rd_req_i,
   input  logic [ICACHE_INDEX_WIDTH-1:0]         rd_index_i,
   output logic                                  rd_ready_o,
   output logic                                  rd_valid_o,
   output logic [NUM_WAYS*ICACHE_DATA_WIDTH-1:0] rd_data_o,
   input  logic                                  fill_start_i,
   input  logic [ICACHE_INDEX_WIDTH-1:0]         fill_index_i,
   input  logic [WAY_W-1:0]                      fill_way_i,
   input  logic                                  fill_beat_valid_i,
   input  logic [BEAT_WIDTH-1:0]                 fill_beat_data_i,
   output logic                                  fill_beat_ready_o,
   output logic                                  fill_busy_o,
   output logic                                  fill_done_o
);

   fill_state_e                   r_state;
   fill_state_e                   w_state_nxt;
   logic [ICACHE_INDEX_WIDTH-1:0] r_fill_index;
   logic [WAY_W-1:0]              r_fill_way;
   logic [CNT_W-1:0]              r_cnt;
   logic                          r_rd_valid;
   logic                          w_rd_accept;
   logic                          w_fill_accept;
   logic                          w_beat_accept;
   logic                          w_last_beat;

   // Reset wins over any request presented in the same cycle.
   assign w_rd_accept   = rd_req_i && (r_state == ST_IDLE) && !rst_i;
   assign w_fill_accept = fill_start_i && (r_state == ST_IDLE) && !rst_i;
   assign w_beat_accept = fill_beat_valid_i && (r_state == ST_FILL) && !rst_i;
   assign w_last_beat   = (r_cnt == CNT_W'(BEATS - 1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (fill_start_i) w_state_nxt = ST_FILL;
         ST_FILL: if (fill_beat_valid_i && w_last_beat) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_rd_valid   <= 1'b0;
         r_fill_index <= '0;
         r_fill_way   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_valid <= w_rd_accept;
         if (w_fill_accept) begin
            r_fill_index <= fill_index_i;
            r_fill_way   <= fill_way_i;
            r_cnt        <= '0;
         end else if (w_beat_accept) begin
            r_cnt <= w_last_beat ? '0 : r_cnt + CNT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
      icache_data_bank #(
         .DATA_W  (ICACHE_DATA_WIDTH),
         .INDEX_W (ICACHE_INDEX_WIDTH),
         .BEAT_W  (BEAT_WIDTH)
      ) u_bank (
         .clk        (clk_i),
         .rst        (rst_i),
         .i_rd_en    (w_rd_accept),
         .i_rd_index (rd_index_i),
         .o_rd_data  (rd_data_o[g*ICACHE_DATA_WIDTH +: ICACHE_DATA_WIDTH]),
         .i_wr_en    (w_beat_accept && (r_fill_way == WAY_W'(g))),
         .i_wr_index (r_fill_index),
         .i_wr_beat  (r_cnt),
         .i_wr_data  (fill_beat_data_i)
      );
   end

   assign rd_ready_o        = (r_state == ST_IDLE);
   assign rd_valid_o        = r_rd_valid;
   assign fill_beat_ready_o = (r_state == ST_FILL);
   assign fill_busy_o       = (r_state != ST_IDLE);
   assign fill_done_o       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_icache_way_data_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_way_data_array
// Brief    : Randomized scoreboard bench for the I-cache way data array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_way_data_array;

   localparam int NW = 2;
   localparam int DW = 256;
   localparam int IW = 6;
   localparam int BW = 64;
   localparam int NB = DW / BW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            rd_req, rd_ready, rd_valid;
   logic [IW-1:0]   rd_index;
   logic [NW*DW-1:0] rd_data;
   logic            fill_start, fill_valid, fill_ready, fill_busy, fill_done;
   logic [IW-1:0]   fill_index;
   logic [0:0]      fill_way;
   logic [BW-1:0]   fill_data;

   icache_way_data_array #(
      .NUM_WAYS(NW), .ICACHE_DATA_WIDTH(DW), .ICACHE_INDEX_WIDTH(IW), .BEAT_WIDTH(BW)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .rd_req_i(rd_req), .rd_index_i(rd_index), .rd_ready_o(rd_ready),
      .rd_valid_o(rd_valid), .rd_data_o(rd_data),
      .fill_start_i(fill_start), .fill_index_i(fill_index), .fill_way_i(fill_way),
      .fill_beat_valid_i(fill_valid), .fill_beat_data_i(fill_data),
      .fill_beat_ready_o(fill_ready), .fill_busy_o(fill_busy), .fill_done_o(fill_done)
   );

   // Single-way, single-beat build.
   logic          s_rd_req, s_rd_ready, s_rd_valid, s_start, s_valid, s_ready, s_busy, s_done;
   logic [IW-1:0] s_rd_index, s_fill_index;
   logic [0:0]    s_way;
   logic [DW-1:0] s_rd_data, s_data;

   icache_way_data_array #(
      .NUM_WAYS(1), .ICACHE_DATA_WIDTH(DW), .ICACHE_INDEX_WIDTH(IW), .BEAT_WIDTH(DW)
   ) dut1 (
      .clk_i(clk), .rst_i(rst),
      .rd_req_i(s_rd_req), .rd_index_i(s_rd_index), .rd_ready_o(s_rd_ready),
      .rd_valid_o(s_rd_valid), .rd_data_o(s_rd_data),
      .fill_start_i(s_start), .fill_index_i(s_fill_index), .fill_way_i(s_way),
      .fill_beat_valid_i(s_valid), .fill_beat_data_i(s_data),
      .fill_beat_ready_o(s_ready), .fill_busy_o(s_busy), .fill_done_o(s_done)
   );

   // Reference contents of every line, updated whenever a beat is handed over.
   logic [DW-1:0] model [NW][2**IW];

   typedef struct {
      logic [NW*DW-1:0] data;
      bit               chk_data;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [NW*DW-1:0] act, input logic [NW*DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] rnd_line();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [NW*DW-1:0] set_of(input int idx);
      logic [NW*DW-1:0] s;
      for (int w = 0; w < NW; w++) s[w*DW +: DW] = model[w][idx];
      return s;
   endfunction

   // Monitor: pops one expectation per rd_valid pulse; otherwise data must hold.
   logic             rst_seen;
   logic [NW*DW-1:0] hold;
   exp_t             mon_e;
   always @(posedge clk) rst_seen <= rst;

   always @(negedge clk) begin
      if (rst_seen === 1'b1) begin
         chk1("rst_rd_valid", rd_valid, 1'b0);
         chk("rst_rd_data", rd_data, '0);
         hold = '0;
      end else if (rst_seen === 1'b0) begin
         if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk1("spurious_rd_valid", 1'b1, 1'b0);
            end else begin
               mon_e = sb.pop_front();
               if (mon_e.chk_data) chk("rd_data", rd_data, mon_e.data);
            end
            hold = rd_data;
         end else begin
            chk("rd_data_hold", rd_data, hold);
         end
      end
   end

   task automatic chk_idle(input string tag);
      chk1({tag, "_busy"}, fill_busy, 1'b0);
      chk1({tag, "_done"}, fill_done, 1'b0);
      chk1({tag, "_beat_ready"}, fill_ready, 1'b0);
      chk1({tag, "_rd_ready"}, rd_ready, 1'b1);
   endtask

   task automatic do_read(input int idx, input bit chk_data);
      chk1("rd_ready_idle", rd_ready, 1'b1);
      rd_req   = 1'b1;
      rd_index = IW'(idx);
      sb.push_back('{set_of(idx), chk_data});
      step();
      rd_req = 1'b0;
   endtask

   // gap < 0: random 0..2 idle cycles before each beat; otherwise that fixed count.
   task automatic fill_line(input int idx, input int way, input logic [DW-1:0] line,
                            input int gap, input bit with_read);
      int g;
      chk1("fill_start_rd_ready", rd_ready, 1'b1);
      fill_start = 1'b1;
      fill_index = IW'(idx);
      fill_way   = 1'(way);
      if (with_read) begin
         rd_req   = 1'b1;
         rd_index = IW'(idx);
         sb.push_back('{set_of(idx), 1'b1});
      end
      step();
      fill_start = 1'b0;
      rd_req     = 1'b0;
      fill_index = IW'($urandom);
      fill_way   = 1'($urandom);
      for (int b = 0; b < NB; b++) begin
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         repeat (g) begin
            chk1("gap_busy", fill_busy, 1'b1);
            chk1("gap_rd_ready", rd_ready, 1'b0);
            chk1("gap_beat_ready", fill_ready, 1'b1);
            chk1("gap_done", fill_done, 1'b0);
            rd_req     = 1'($urandom);
            rd_index   = IW'($urandom);
            fill_start = 1'($urandom);
            fill_data  = BW'({$urandom, $urandom});
            step();
         end
         rd_req     = 1'b0;
         fill_start = 1'b0;
         fill_valid = 1'b1;
         fill_data  = line[b*BW +: BW];
         chk1("beat_ready", fill_ready, 1'b1);
         chk1("beat_busy", fill_busy, 1'b1);
         step();
         model[way][idx][b*BW +: BW] = line[b*BW +: BW];
         fill_valid = 1'b0;
      end
      chk1("fill_done_pulse", fill_done, 1'b1);
      chk1("done_busy", fill_busy, 1'b1);
      chk1("done_rd_ready", rd_ready, 1'b0);
      chk1("done_beat_ready", fill_ready, 1'b0);
      step();
      chk_idle("after_done");
   endtask

   initial begin
      logic [DW-1:0] line;
      rst = 1'b1;
      {rd_req, fill_start, fill_valid} = '0;
      rd_index = '0; fill_index = '0; fill_way = '0; fill_data = '0;
      {s_rd_req, s_start, s_valid} = '0;
      s_rd_index = '0; s_fill_index = '0; s_way = '0; s_data = '0;
      hold = '0;
      @(negedge clk);
      step();
      rst = 1'b0;
      chk_idle("reset");

      // Read with no fill: only the pulse timing matters, contents are unknown.
      do_read(5, 1'b0);
      chk1("read5_busy", fill_busy, 1'b0);
      step();

      for (int w = 0; w < NW; w++)
         for (int i = 0; i < 2**IW; i++)
            fill_line(i, w, rnd_line(), 0, 1'b0);

      line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
      fill_line(3, 1, line, 0, 1'b0);
      do_read(3, 1'b1);
      fill_line(9, 1, line, 2, 1'b0);
      do_read(9, 1'b1);

      fill_line(7, 0, rnd_line(), -1, 1'b1);
      do_read(7, 1'b1);

      // Reset after two of four beats; a concurrent third beat must be dropped.
      line = rnd_line();
      fill_start = 1'b1; fill_index = 6'd12; fill_way = 1'b0;
      step();
      fill_start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         fill_valid = 1'b1; fill_data = line[b*BW +: BW];
         step();
         model[0][12][b*BW +: BW] = line[b*BW +: BW];
      end
      rst = 1'b1; fill_data = line[2*BW +: BW]; rd_req = 1'b1;
      step();
      rst = 1'b0; fill_valid = 1'b0; rd_req = 1'b0;
      chk_idle("mid_fill_reset");
      step();
      chk1("no_done_after_reset", fill_done, 1'b0);
      do_read(12, 1'b1);
      fill_line(12, 1, rnd_line(), -1, 1'b0);
      do_read(12, 1'b1);

      // Single-beat configuration.
      line = rnd_line();
      chk1("s_idle_busy", s_busy, 1'b0);
      s_start = 1'b1; s_fill_index = 6'd21;
      step();
      s_start = 1'b0;
      chk1("s_beat_ready", s_ready, 1'b1);
      s_valid = 1'b1; s_data = line;
      step();
      s_valid = 1'b0;
      chk1("s_done", s_done, 1'b1);
      chk1("s_rd_blocked", s_rd_ready, 1'b0);
      step();
      chk1("s_done_clear", s_done, 1'b0);
      chk1("s_busy_clear", s_busy, 1'b0);
      s_rd_req = 1'b1; s_rd_index = 6'd21;
      step();
      s_rd_req = 1'b0;
      chk1("s_rd_valid", s_rd_valid, 1'b1);
      chk("s_rd_data", {{DW{1'b0}}, s_rd_data}, {{DW{1'b0}}, line});
      step();
      chk1("s_rd_valid_pulse", s_rd_valid, 1'b0);

      repeat (60) begin
         if ($urandom_range(0, 2) == 0)
            do_read(int'($urandom_range(0, 2**IW - 1)), 1'b1);
         else
            fill_line(int'($urandom_range(0, 2**IW - 1)), int'($urandom_range(0, NW - 1)),
                      rnd_line(), -1, 1'($urandom));
      end

      repeat (3) step();
      chk("sb_drained", (NW*DW)'(sb.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
